// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory command/return signals for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_Enb;
  logic              i_if_req;
  logic [ADDR_W-1:0] iv_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] ov_if_rdata;
  logic              i_ls_req;
  logic              i_ls_we;
  logic [ADDR_W-1:0] iv_ls_addr;
  logic [DATA_W-1:0] iv_ls_wdata;
  logic [BE_W-1:0]   iv_ls_be;
  logic              o_ls_gnt;
  logic              o_ls_rvalid;
  logic [DATA_W-1:0] ov_ls_rdata;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] ov_mem_addr;
  logic [DATA_W-1:0] ov_mem_wdata;
  logic [BE_W-1:0]   ov_mem_be;
  logic [DATA_W-1:0] iv_mem_rdata;
  logic              o_busy;

  modport slave (
    input  i_Enb, i_if_req, iv_if_addr, i_ls_req, i_ls_we, iv_ls_addr, iv_ls_wdata,
           iv_ls_be, iv_mem_rdata,
    output o_if_gnt, o_if_rvalid, ov_if_rdata, o_ls_gnt, o_ls_rvalid, ov_ls_rdata,
           o_mem_en, o_mem_we, ov_mem_addr, ov_mem_wdata, ov_mem_be, o_busy
  );

  modport master (
    output i_Enb, i_if_req, iv_if_addr, i_ls_req, i_ls_we, iv_ls_addr, iv_ls_wdata,
           iv_ls_be, iv_mem_rdata,
    input  o_if_gnt, o_if_rvalid, ov_if_rdata, o_ls_gnt, o_ls_rvalid, ov_ls_rdata,
           o_mem_en, o_mem_we, ov_mem_addr, ov_mem_wdata, ov_mem_be, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one single-port memory, with read-owner tag pipeline.
// Define ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_MAX denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              i_Clk,
  input logic              i_Rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = MEM_LAT + 1;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..4");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  typedef struct packed {
    logic valid;
    logic owner_ls;
  } tag_t;

  logic              force_if;
  logic              if_gnt, ls_gnt, accept;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  tag_t [DEPTH-1:0]  tag_q, tag_d;
  logic              busy;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt)
      starve_cnt_d = '0;
    else if (bus.i_Enb && bus.i_if_req && !force_if)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // Load/store wins unless the starvation guard has tripped while fetch is waiting.
  assign if_gnt = !i_Rst && bus.i_Enb && bus.i_if_req && (!bus.i_ls_req || force_if);
  assign ls_gnt = !i_Rst && bus.i_Enb && bus.i_ls_req && !(force_if && bus.i_if_req);
  assign accept = if_gnt || ls_gnt;

  always_comb begin
    mem_en_d    = accept;
    mem_we_d    = ls_gnt && bus.i_ls_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (ls_gnt) begin
      mem_addr_d  = bus.iv_ls_addr;
      mem_wdata_d = bus.iv_ls_wdata;
      mem_be_d    = bus.i_ls_we ? bus.iv_ls_be : {BE_W{1'b1}};
    end else if (if_gnt) begin
      mem_addr_d = bus.iv_if_addr;
      mem_be_d   = {BE_W{1'b1}};
    end
  end

  // Stores ride the pipeline as bubbles so read returns stay aligned to issue order.
  always_comb begin
    tag_d[0] = {accept && !(ls_gnt && bus.i_ls_we), ls_gnt};
    for (int i = 1; i < DEPTH; i++)
      tag_d[i] = tag_q[i-1];
    if_rvalid_d = tag_q[DEPTH-1].valid && !tag_q[DEPTH-1].owner_ls;
    ls_rvalid_d = tag_q[DEPTH-1].valid && tag_q[DEPTH-1].owner_ls;
    if_rdata_d  = if_rvalid_d ? bus.iv_mem_rdata : if_rdata_q;
    ls_rdata_d  = ls_rvalid_d ? bus.iv_mem_rdata : ls_rdata_q;
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      busy = busy | tag_q[i].valid;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      tag_q       <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.o_if_gnt     = if_gnt;
  assign bus.o_ls_gnt     = ls_gnt;
  assign bus.o_mem_en     = mem_en_q;
  assign bus.o_mem_we     = mem_we_q;
  assign bus.ov_mem_addr  = mem_addr_q;
  assign bus.ov_mem_wdata = mem_wdata_q;
  assign bus.ov_mem_be    = mem_be_q;
  assign bus.o_if_rvalid  = if_rvalid_q;
  assign bus.ov_if_rdata  = if_rdata_q;
  assign bus.o_ls_rvalid  = ls_rvalid_q;
  assign bus.ov_ls_rdata  = ls_rdata_q;
  assign bus.o_busy       = busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset, enable and starvation sequences.
// Memory is modelled as word(addr) = addr ^ 0xC0DE0000 returned MEM_LAT cycles after a read command.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: capture the command mid-cycle, present read data MEM_LAT cycles later.
  logic        cap_rd;
  logic [31:0] cap_addr;
  logic [31:0] mpipe [MEM_LAT];

  always @(negedge clk) begin
    cap_rd   = bus.o_mem_en & ~bus.o_mem_we;
    cap_addr = bus.ov_mem_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int i = MEM_LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
    mpipe[0] = (cap_rd === 1'b1) ? mem_word(cap_addr) : 32'hBAD0_0000;
    bus.iv_mem_rdata = mpipe[MEM_LAT-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        enb;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        chk_wd;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic        e_ls_rv;
    logic        e_busy;
    logic [31:0] e_if_rd;
    logic [31:0] e_ls_rd;
  } vec_t;

  vec_t vt [12];

  task automatic drive(input logic if_req, input logic [31:0] if_addr, input logic ls_req,
                       input logic ls_we, input logic [31:0] ls_addr, input logic enb);
    bus.i_if_req    = if_req;
    bus.iv_if_addr  = if_addr;
    bus.i_ls_req    = ls_req;
    bus.i_ls_we     = ls_we;
    bus.iv_ls_addr  = ls_addr;
    bus.i_Enb       = enb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ifr if_addr       lsr we ls_addr       ls_wdata      be    enb | ig lg en we addr          be    cw wdata         irv lrv bsy if_rdata      ls_rdata
    vt[0]  = '{0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 1,   0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0};
    vt[1]  = '{1, 32'h10,        0, 0, 32'h0,         32'h0,        4'h0, 1,   1, 0, 1, 0, 32'h10,       4'hF, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0};
    vt[2]  = '{0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 1,   0, 0, 0, 0, 32'h10,       4'hF, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0};
    vt[3]  = '{1, 32'h20,        1, 0, 32'h100,       32'h0,        4'h0, 1,   0, 1, 1, 0, 32'h100,      4'hF, 0, 32'h0,        1, 0, 1, 32'hC0DE0010, 32'h0};
    vt[4]  = '{1, 32'h20,        0, 0, 32'h0,         32'h0,        4'h0, 1,   1, 0, 1, 0, 32'h20,       4'hF, 0, 32'h0,        0, 0, 1, 32'hC0DE0010, 32'h0};
    vt[5]  = '{0, 32'h0,         1, 1, 32'h104,       32'hDEADBEEF, 4'h3, 1,   0, 1, 1, 1, 32'h104,      4'h3, 1, 32'hDEADBEEF, 0, 1, 1, 32'hC0DE0010, 32'hC0DE0100};
    vt[6]  = '{1, 32'h30,        0, 0, 32'h0,         32'h0,        4'h0, 0,   0, 0, 0, 0, 32'h104,      4'h3, 0, 32'h0,        1, 0, 0, 32'hC0DE0020, 32'hC0DE0100};
    vt[7]  = '{0, 32'h0,         1, 0, 32'h300,       32'h0,        4'h0, 0,   0, 0, 0, 0, 32'h104,      4'h3, 0, 32'h0,        0, 0, 0, 32'hC0DE0020, 32'hC0DE0100};
    vt[8]  = '{1, 32'h40,        1, 1, 32'h200,       32'h12345678, 4'hC, 1,   0, 1, 1, 1, 32'h200,      4'hC, 1, 32'h12345678, 0, 0, 0, 32'hC0DE0020, 32'hC0DE0100};
    vt[9]  = '{1, 32'h40,        0, 0, 32'h0,         32'h0,        4'h0, 1,   1, 0, 1, 0, 32'h40,       4'hF, 0, 32'h0,        0, 0, 1, 32'hC0DE0020, 32'hC0DE0100};
    vt[10] = '{0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 1,   0, 0, 0, 0, 32'h40,       4'hF, 0, 32'h0,        0, 0, 1, 32'hC0DE0020, 32'hC0DE0100};
    vt[11] = '{0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 1,   0, 0, 0, 0, 32'h40,       4'hF, 0, 32'h0,        1, 0, 0, 32'hC0DE0040, 32'hC0DE0100};

    // Reset held with both requesters active: grants and all registered outputs stay 0.
    rst = 1'b1;
    drive(1, 32'h10, 1, 0, 32'h100, 1);
    bus.iv_ls_wdata = 32'h0;
    bus.iv_ls_be    = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst if_gnt",   32'(bus.o_if_gnt),    32'h0);
    chk("rst ls_gnt",   32'(bus.o_ls_gnt),    32'h0);
    chk("rst mem_en",   32'(bus.o_mem_en),    32'h0);
    chk("rst mem_we",   32'(bus.o_mem_we),    32'h0);
    chk("rst mem_addr", bus.ov_mem_addr,      32'h0);
    chk("rst mem_wd",   bus.ov_mem_wdata,     32'h0);
    chk("rst mem_be",   32'(bus.ov_mem_be),   32'h0);
    chk("rst if_rv",    32'(bus.o_if_rvalid), 32'h0);
    chk("rst ls_rv",    32'(bus.o_ls_rvalid), 32'h0);
    chk("rst if_rd",    bus.ov_if_rdata,      32'h0);
    chk("rst ls_rd",    bus.ov_ls_rdata,      32'h0);
    chk("rst busy",     32'(bus.o_busy),      32'h0);
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i].if_req, vt[i].if_addr, vt[i].ls_req, vt[i].ls_we, vt[i].ls_addr, vt[i].enb);
      bus.iv_ls_wdata = vt[i].ls_wdata;
      bus.iv_ls_be    = vt[i].ls_be;
      #1;
      chk($sformatf("v%0d if_gnt", i), 32'(bus.o_if_gnt), 32'(vt[i].e_if_gnt));
      chk($sformatf("v%0d ls_gnt", i), 32'(bus.o_ls_gnt), 32'(vt[i].e_ls_gnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_en", i),   32'(bus.o_mem_en),    32'(vt[i].e_en));
      chk($sformatf("v%0d mem_we", i),   32'(bus.o_mem_we),    32'(vt[i].e_we));
      chk($sformatf("v%0d mem_addr", i), bus.ov_mem_addr,      vt[i].e_addr);
      chk($sformatf("v%0d mem_be", i),   32'(bus.ov_mem_be),   32'(vt[i].e_be));
      if (vt[i].chk_wd)
        chk($sformatf("v%0d mem_wdata", i), bus.ov_mem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d if_rvalid", i), 32'(bus.o_if_rvalid), 32'(vt[i].e_if_rv));
      chk($sformatf("v%0d ls_rvalid", i), 32'(bus.o_ls_rvalid), 32'(vt[i].e_ls_rv));
      chk($sformatf("v%0d busy", i),      32'(bus.o_busy),      32'(vt[i].e_busy));
      chk($sformatf("v%0d if_rdata", i),  bus.ov_if_rdata,      vt[i].e_if_rd);
      chk($sformatf("v%0d ls_rdata", i),  bus.ov_ls_rdata,      vt[i].e_ls_rd);
    end

    // Enable low with one fetch in flight: no grants, but the return still lands on time.
    @(negedge clk);
    drive(1, 32'h50, 0, 0, 32'h0, 1);
    #1;
    chk("enb accept if_gnt", 32'(bus.o_if_gnt), 32'h1);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1, 32'h60, 0, 0, 32'h0, 0);
      #1;
      chk($sformatf("enb0 c%0d if_gnt", k), 32'(bus.o_if_gnt), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("enb0 c%0d if_rvalid", k), 32'(bus.o_if_rvalid), 32'(k == MEM_LAT + 1));
      if (k == MEM_LAT + 1)
        chk("enb0 if_rdata", bus.ov_if_rdata, 32'hC0DE0050);
    end

    // Reset pulse with two reads in flight: they are dropped for good.
    @(negedge clk);
    drive(1, 32'h70, 0, 0, 32'h0, 1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h74, 1);
    @(posedge clk);
    #1;
    chk("pre-rst busy", 32'(bus.o_busy), 32'h1);
    @(negedge clk);
    drive(1, 32'h78, 1, 0, 32'h7C, 1);
    rst = 1'b1;
    #1;
    chk("mid-rst if_gnt", 32'(bus.o_if_gnt), 32'h0);
    chk("mid-rst ls_gnt", 32'(bus.o_ls_gnt), 32'h0);
    chk("mid-rst mem_en", 32'(bus.o_mem_en), 32'h0);
    chk("mid-rst busy",   32'(bus.o_busy),   32'h0);
    @(posedge clk);
    #1;
    chk("mid-rst mem_en edge", 32'(bus.o_mem_en), 32'h0);
    chk("mid-rst rvalid",      32'({bus.o_if_rvalid, bus.o_ls_rvalid}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst c%0d if_rvalid", k), 32'(bus.o_if_rvalid), 32'h0);
      chk($sformatf("post-rst c%0d ls_rvalid", k), 32'(bus.o_ls_rvalid), 32'h0);
      chk($sformatf("post-rst c%0d busy", k),      32'(bus.o_busy),      32'h0);
    end

    // Both requesters held high: LS priority, optionally broken by the starvation guard.
    for (int c = 1; c <= 6; c++) begin
      logic e_if;
`ifdef ARB_STARVE_GUARD_EN
      e_if = (c == STARVE_MAX + 1);
`else
      e_if = 1'b0;
`endif
      @(negedge clk);
      drive(1, 32'h90, 1, 0, 32'h80, 1);
      #1;
      chk($sformatf("starve c%0d if_gnt", c), 32'(bus.o_if_gnt), 32'(e_if));
      chk($sformatf("starve c%0d ls_gnt", c), 32'(bus.o_ls_gnt), 32'(!e_if));
      @(posedge clk);
    end
    @(negedge clk);
    drive(1, 32'h90, 0, 0, 32'h0, 1);
    #1;
    chk("starve release if_gnt", 32'(bus.o_if_gnt), 32'h1);
    chk("starve release ls_gnt", 32'(bus.o_ls_gnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("drain busy", 32'(bus.o_busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
